sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
- Second-generation synchronous FIFO for the verification-projects datapath.
- Parametrised in data width and depth; non-power-of-two depths are supported.
- Adds run-time programmable almost-full/almost-empty thresholds, a live occupancy output, a synchronous flush, and a defined simultaneous read+write at full.
- Drop-in producer/consumer buffer between stimulus-side and checker-side logic.

Parameters:
DATA_WIDTH, 16, width of wr_data/rd_data
FIFO_DEPTH, 8, number of entries; any value >= 2
PTR_W, $clog2(FIFO_DEPTH), pointer width (derived, not overridden)
CNT_W, $clog2(FIFO_DEPTH+1), width of count and thresholds (derived)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents; rst has priority
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  read data
afull_th  in  CNT_W  almost-full threshold, quasi-static
aempty_th  in  CNT_W  almost-empty threshold, quasi-static
count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  !full && count >= afull_th
almostempty  out  1  !empty && count <= aempty_th
wr_ack  out  1  registered; previous-cycle write accepted
overflow  out  1  registered; previous-cycle write rejected
underflow  out  1  registered; previous-cycle read rejected

Behaviour:
- Reset: the cycle after rst=1, wr_ptr=rd_ptr=count=0.
  - rd_data=0; wr_ack, overflow and underflow are 0.
  - Flags follow count: empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not cleared.
- flush: identical to reset for pointers, count, wr_ack, overflow and underflow; rd_data holds its value.
  - wr_en/rd_en in a flush cycle are ignored; no ack and no error is reported.
- Write accepted when wr_en && (!full || rd_en). A write at full with a simultaneous read is accepted.
  - Accepted write: mem[wr_ptr] <= wr_data.
  - wr_ptr advances; it wraps FIFO_DEPTH-1 -> 0 explicitly, with no modulo of 2^PTR_W.
- Read accepted when rd_en && !empty.
  - Empty with rd_en && wr_en: the write is accepted, the read is rejected, underflow=1.
- count next value:
  - +1 on write-only; -1 on read-only.
  - Unchanged on both accepted or neither accepted.
  - Never exceeds FIFO_DEPTH and never goes below 0.
- wr_ack is 1 in cycle N+1 iff the write in cycle N was accepted.
- overflow is 1 in cycle N+1 iff wr_en && full && !rd_en in cycle N.
- underflow is 1 in cycle N+1 iff rd_en && empty in cycle N.
- Flags are combinational from count and the thresholds; no extra latency.
  - afull_th=0 forces almostfull whenever !full.
  - aempty_th >= FIFO_DEPTH forces almostempty whenever !empty.
- Read latency (default): rd_data <= mem[rd_ptr] one cycle after an accepted read; it holds otherwise.
- Mid-operation reset: any in-flight read result is discarded; rd_data=0 the next cycle.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through. rd_data continuously presents mem[rd_ptr] whenever !empty, and presents 0 when empty.
  - An accepted read pops the head; the next entry is visible in the following cycle.
  - There is zero-cycle read latency; rd_en acts as an acknowledge.
- Undefined: registered one-cycle read latency as described in Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - Default DATA_WIDTH/FIFO_DEPTH localparams.
  - Typedefs ptr_t and cnt_t.
  - An enum for op decode: OP_IDLE, OP_WR, OP_RD, OP_WR_RD.
- Sub-module fifo_mem:
  - Simple dual-port RAM, FIFO_DEPTH x DATA_WIDTH.
  - Synchronous write port.
  - Read port is registered normally and asynchronous under SYNC_FIFO_FWFT_EN.

Test Plan (DEPTH=8, WIDTH=16, afull_th=7, aempty_th=1 unless stated):
- rst=1 for 2 cycles mid-traffic with count=5 -> next cycle count=0, empty=1, wr_ptr=rd_ptr=0, wr_ack=overflow=underflow=0, rd_data=0.
- Write 0x0001..0x0008 back-to-back, then 9th write 0xDEAD -> wr_ack=1 for 8 cycles, full=1 at count=8, almostfull=1 only at count=7, overflow=1 the cycle after the 9th write, 0xDEAD never read.
- At full, wr_en=rd_en=1 with 0x00AA for 12 cycles -> count stays 8, no overflow, reads return 0x0001..0x0008 then 0x00AA..., both pointers wrap 7->0.
- Empty, rd_en=wr_en=1 with 0x1234 -> underflow=1 next cycle, count=1, almostempty=1; next read returns 0x1234.
- afull_th=3, aempty_th=5, fill to 4 -> almostfull=1 and almostempty=1 simultaneously; flush -> count=0, empty=1, no wr_ack, rd_data unchanged.
- FIFO_DEPTH=6 build: 20 writes interleaved with 20 reads -> pointers wrap 5->0, data order preserved; with SYNC_FIFO_FWFT_EN, rd_data shows 1st word in the cycle after its write, before any rd_en.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the programmable synchronous FIFO:
//   - default geometry (DEF_DATA_WIDTH, DEF_FIFO_DEPTH)
//   - ptr_t / cnt_t sized for the default geometry
//   - op_e: per-cycle operation decode (idle / write / read / both)
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef logic [$clog2(DEF_FIFO_DEPTH)-1:0]   ptr_t;
    typedef logic [$clog2(DEF_FIFO_DEPTH+1)-1:0] cnt_t;

    // Encoding is {read_accepted, write_accepted}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WR    = 2'b01,
        OP_RD    = 2'b10,
        OP_WR_RD = 2'b11
    } op_e;

    function automatic op_e op_decode(input logic wr_acc, input logic rd_acc);
        return op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage, FIFO_DEPTH x DATA_WIDTH, contents never cleared.
//   clk      : clock
//   rst      : synchronous active-high reset (clears the registered read data)
//   we_i     : write enable, waddr_i / wdata_i : write address / data
//   re_i     : read enable, raddr_i : read address
//   rdata_o  : read data
// Build option SYNC_FIFO_FWFT_EN: read port becomes asynchronous
// (rdata_o = mem[raddr_i]); otherwise rdata_o is registered, loaded on re_i
// and holding otherwise.
// -----------------------------------------------------------------------------
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Write port: storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_s;
    assign unused_s = &{1'b0, rst, re_i};
    assign rdata_o  = mem_q[raddr_i];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read port: reset clears, accepted read loads, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// live occupancy, synchronous flush and defined read+write at full.
// Ports:
//   clk, rst (sync, active-high), flush (sync clear, rst has priority)
//   wr_en / wr_data     : write request / data
//   rd_en / rd_data     : read request / data
//   afull_th, aempty_th : quasi-static thresholds (CNT_W bits)
//   count               : occupancy 0..FIFO_DEPTH
//   full, empty, almostfull, almostempty : combinational flags from count
//   wr_ack, overflow, underflow          : registered status of previous cycle
// Build option SYNC_FIFO_FWFT_EN: first-word-fall-through read data
// (head shown while not empty, 0 when empty); default is one-cycle
// registered read latency.
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [CNT_W-1:0]      afull_th,
    input  logic [CNT_W-1:0]      aempty_th,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  full_s, empty_s;
    logic                  wr_acc_s, rd_acc_s;
    op_e                   op_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    // Explicit wrap so non-power-of-two depths never touch unused slots
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH-1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Full with a simultaneous read still accepts the write: the read frees
    // the slot in the same cycle. Flush/reset cycles accept nothing.
    assign wr_acc_s = wr_en & (~full_s | rd_en) & ~flush & ~rst;
    assign rd_acc_s = rd_en & ~empty_s & ~flush & ~rst;

    // Next-state pointers and occupancy from the decoded operation
    always_comb begin
        op_s     = op_decode(wr_acc_s, rd_acc_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case (op_s)
            OP_WR:    count_d = count_q + CNT_W'(1);
            OP_RD:    count_d = count_q - CNT_W'(1);
            OP_IDLE:  count_d = count_q;
            OP_WR_RD: count_d = count_q;
            default:  count_d = count_q;
        endcase
    end

    // State registers; reset and flush clear identically (read data is
    // handled in fifo_mem, where flush leaves it untouched)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc_s;
            overflow_q  <= wr_en & full_s & ~rd_en;
            underflow_q <= rd_en & empty_s;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = empty_s ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
`else
    assign rd_data = mem_rdata_s;
`endif

    assign count       = count_q;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almostfull  = ~full_s & (count_q >= afull_th);
    assign almostempty = ~empty_s & (count_q <= aempty_th);
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
